// File: rtl/nv_nvdla_hls_shiftleftsat_pipe.sv
// Purpose: signed left shift by a per-sample amount, saturated to OUT_WIDTH bits, with a saturation event counter.
// Latency: two register stages; one sample per cycle when not stalled.
// Backpressure: valid/ready; in_prdy follows out_prdy combinationally, and both stages hold while the output is stalled.
module nv_nvdla_hls_shiftleftsat_pipe #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 49,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_sat,
  input  logic                   sat_cnt_clr,
  output logic [31:0]            sat_cnt
);

  // The widest shift needs IN_WIDTH + 2^SHIFT_WIDTH - 1 bits; one spare bit keeps
  // the top bit a guaranteed copy of the sign so no result bit is ever lost.
  localparam int FULL_W = IN_WIDTH + (1 << SHIFT_WIDTH);
  // Bits from the output sign position upward must all equal the input sign.
  localparam int HI_W   = FULL_W - OUT_WIDTH + 1;

  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [FULL_W-1:0]    in_ext;
  logic [FULL_W-1:0]    shifted;
  logic [HI_W-1:0]      hi_bits;
  logic                 in_neg;
  logic                 in_ovf;

  logic                 s1_vld;
  logic [OUT_WIDTH-1:0] s1_lo;
  logic                 s1_ovf;
  logic                 s1_neg;
  logic [OUT_WIDTH-1:0] s1_result;
  logic                 s2_adv;

  // Exact shift and overflow decision: out of range whenever any bit at or
  // above the output sign position differs from the input sign.
  always_comb begin
    in_ext  = {{(FULL_W-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    shifted = in_ext << in_shift;
    hi_bits = shifted[FULL_W-1:OUT_WIDTH-1];
    in_neg  = in_data[IN_WIDTH-1];
    in_ovf  = in_neg ? ~(&hi_bits) : (|hi_bits);
  end

  // Stage 2 takes a new sample when empty or when its current one leaves;
  // stage 1 (and therefore the input) can move whenever stage 2 can.
  assign s2_adv  = !out_pvld || out_prdy;
  assign in_prdy = !s1_vld || s2_adv;

  // Clamp to the signed extreme matching the sample's sign on overflow.
  always_comb begin
    s1_result = s1_lo;
    if (s1_ovf) begin
      s1_result = s1_neg ? SAT_MIN : SAT_MAX;
    end
  end

  // Stage 1: low result bits plus overflow/sign decision.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld <= 1'b0;
      s1_lo  <= '0;
      s1_ovf <= 1'b0;
      s1_neg <= 1'b0;
    end else if (in_prdy) begin
      s1_vld <= in_pvld;
      if (in_pvld) begin
        s1_lo  <= shifted[OUT_WIDTH-1:0];
        s1_ovf <= in_ovf;
        s1_neg <= in_neg;
      end
    end
  end

  // Stage 2: registered outputs, held stable while stalled.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_pvld <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (s2_adv) begin
      out_pvld <= s1_vld;
      if (s1_vld) begin
        out_data <= s1_result;
        out_sat  <= s1_ovf;
      end
    end
  end

  // Saturation counter: counts delivered saturated samples, sticks at all-ones,
  // and a clear wins over a same-cycle increment.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_pvld && out_prdy && out_sat && (sat_cnt != 32'hFFFF_FFFF)) begin
      sat_cnt <= sat_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_hls_shiftleftsat_pipe.sv
// Purpose: randomized and directed bench for the saturating left-shift pipe.
// Latency: checks ordering and values through a scoreboard queue, not exact cycle counts.
// Backpressure: exercises random and long out_prdy stalls, including a full pipe.
module tb_nv_nvdla_hls_shiftleftsat_pipe;

  localparam int IW = 32;
  localparam int OW = 49;
  localparam int SW = 6;

  typedef struct {
    logic [OW-1:0] data;
    logic          sat;
  } exp_t;

  logic          clk;
  logic          rstn;
  logic          in_pvld;
  logic          in_prdy;
  logic [IW-1:0] in_data;
  logic [SW-1:0] in_shift;
  logic          out_pvld;
  logic          out_prdy;
  logic [OW-1:0] out_data;
  logic          out_sat;
  logic          sat_cnt_clr;
  logic [31:0]   sat_cnt;

  int checks;
  int failures;

  exp_t        exp_q[$];
  logic [31:0] cnt_model;
  logic [31:0] preset_val;
  int          preset_seq;
  int          preset_seen;

  nv_nvdla_hls_shiftleftsat_pipe #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .in_pvld        (in_pvld),
    .in_prdy        (in_prdy),
    .in_data        (in_data),
    .in_shift       (in_shift),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_data       (out_data),
    .out_sat        (out_sat),
    .sat_cnt_clr    (sat_cnt_clr),
    .sat_cnt        (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: exact product with wide signed arithmetic, then range clamp.
  function automatic exp_t model(input logic [IW-1:0] d, input logic [SW-1:0] sh);
    logic signed [127:0] ex;
    logic signed [127:0] pw;
    logic signed [127:0] mx;
    logic signed [127:0] mn;
    exp_t r;
    ex = {{(128-IW){d[IW-1]}}, d};
    pw = 128'sd1;
    pw = pw <<< sh;
    ex = ex * pw;
    mx = 128'sd1;
    mx = (mx <<< (OW-1)) - 128'sd1;
    mn = -mx - 128'sd1;
    if (ex > mx) begin
      r.data = {1'b0, {(OW-1){1'b1}}};
      r.sat  = 1'b1;
    end else if (ex < mn) begin
      r.data = {1'b1, {(OW-1){1'b0}}};
      r.sat  = 1'b1;
    end else begin
      r.data = ex[OW-1:0];
      r.sat  = 1'b0;
    end
    return r;
  endfunction

  // Monitor/scoreboard: all sampling on the falling edge, mid-cycle.
  logic          prev_stall;
  logic [OW-1:0] prev_data;
  logic          prev_sat;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      exp_q.delete();
      cnt_model  = 32'd0;
      prev_stall = 1'b0;
    end else begin
      if (preset_seq != preset_seen) begin
        cnt_model   = preset_val;
        preset_seen = preset_seq;
      end
      chk("sat_cnt", {32'd0, sat_cnt}, {32'd0, cnt_model});
      if (prev_stall) begin
        chk("stall_pvld", {63'd0, out_pvld}, 64'd1);
        chk("stall_data", {15'd0, out_data}, {15'd0, prev_data});
        chk("stall_sat", {63'd0, out_sat}, {63'd0, prev_sat});
      end
      if (out_pvld && out_prdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {15'd0, out_data}, {15'd0, e.data});
          chk("out_sat", {63'd0, out_sat}, {63'd0, e.sat});
          if (!sat_cnt_clr && e.sat && cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 32'd1;
        end
      end
      if (sat_cnt_clr) cnt_model = 32'd0;
      if (in_pvld && in_prdy) exp_q.push_back(model(in_data, in_shift));
      prev_stall = out_pvld && !out_prdy;
      prev_data  = out_data;
      prev_sat   = out_sat;
    end
  end

  // Present one sample (called just after a rising edge) and hold it until taken.
  task automatic send(input logic [IW-1:0] d, input logic [SW-1:0] sh);
    logic done;
    done     = 1'b0;
    in_pvld  = 1'b1;
    in_data  = d;
    in_shift = sh;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_prdy) done = 1'b1;
      @(posedge clk); #1;
      if (done) break;
    end
    in_pvld = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain();
    logic empty;
    empty    = 1'b0;
    out_prdy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_pvld) begin
        empty = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (!empty) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
  endtask

  function automatic logic [IW-1:0] rnd_data();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return IW'($urandom_range(0, 255));
      default: return IW'($urandom);
    endcase
  endfunction

  function automatic logic [SW-1:0] rnd_shift();
    if ($urandom_range(0, 1) == 0) return SW'($urandom_range(10, 63));
    return SW'($urandom_range(0, 63));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    logic acc;
    checks      = 0;
    failures    = 0;
    preset_seq  = 0;
    preset_seen = 0;
    preset_val  = '0;
    cnt_model   = '0;
    rstn        = 1'b0;
    in_pvld     = 1'b0;
    in_data     = '0;
    in_shift    = '0;
    out_prdy    = 1'b0;
    sat_cnt_clr = 1'b0;
    #2;
    chk("rst_pvld", {63'd0, out_pvld}, 64'd0);
    chk("rst_data", {15'd0, out_data}, 64'd0);
    chk("rst_sat_cnt", {32'd0, sat_cnt}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_in_prdy", {63'd0, in_prdy}, 64'd1);
    @(posedge clk); #1;

    // Boundary samples around the positive and negative limits and zero input.
    out_prdy = 1'b1;
    send(32'h0000_0001, 6'd47);
    send(32'h0000_0001, 6'd48);
    send(32'hFFFF_FFFF, 6'd48);
    send(32'hFFFF_FFFF, 6'd49);
    send(32'h0000_0000, 6'd63);
    drain();
    chk("boundary_sat_cnt", {32'd0, sat_cnt}, 64'd2);

    // Full stall: three samples offered, only two fit, then all drain in order.
    out_prdy = 1'b0;
    acc_cnt  = 0;
    in_pvld  = 1'b1;
    in_data  = 32'h0000_0011;
    in_shift = 6'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc = in_prdy;
      @(posedge clk); #1;
      if (acc) begin
        acc_cnt++;
        in_data  = (acc_cnt == 1) ? 32'hFFFF_FF00 : 32'h0000_0333;
        in_shift = (acc_cnt == 1) ? 6'd5 : 6'd60;
      end
    end
    chk("stall_accepted", 64'(acc_cnt), 64'd2);
    @(negedge clk);
    chk("stall_in_prdy", {63'd0, in_prdy}, 64'd0);
    @(posedge clk); #1;
    out_prdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("burst_pvld", {63'd0, out_pvld}, 64'd1);
      acc = in_pvld && in_prdy;
      @(posedge clk); #1;
      if (acc) in_pvld = 1'b0;
    end
    drain();

    // Clear on the same edge as a saturated transfer wins.
    out_prdy = 1'b0;
    send(32'h0000_0001, 6'd48);
    @(posedge clk); #1;
    out_prdy    = 1'b1;
    sat_cnt_clr = 1'b1;
    @(posedge clk); #1;
    sat_cnt_clr = 1'b0;
    chk("clr_priority", {32'd0, sat_cnt}, 64'd0);
    drain();

    // Counter sticks at all-ones.
    out_prdy   = 1'b0;
    preset_val = 32'hFFFF_FFFE;
    preset_seq = preset_seq + 1;
    force dut.sat_cnt = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.sat_cnt;
    out_prdy = 1'b1;
    send(32'h8000_0000, 6'd40);
    send(32'h7FFF_FFFF, 6'd30);
    send(32'h0000_0005, 6'd63);
    drain();
    chk("sat_cnt_stick", {32'd0, sat_cnt}, 64'h0000_0000_FFFF_FFFF);

    // Randomized traffic with random backpressure and occasional clears.
    acc = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!in_pvld || acc) begin
        in_pvld  = ($urandom_range(0, 3) != 0);
        in_data  = rnd_data();
        in_shift = rnd_shift();
      end
      out_prdy    = ($urandom_range(0, 3) != 0);
      sat_cnt_clr = ($urandom_range(0, 40) == 0);
      @(negedge clk);
      acc = in_pvld && in_prdy;
      @(posedge clk); #1;
    end
    in_pvld     = 1'b0;
    sat_cnt_clr = 1'b0;
    drain();

    // Reset with two samples in flight.
    out_prdy = 1'b0;
    send(32'h0000_0123, 6'd4);
    send(32'h0000_0456, 6'd8);
    @(negedge clk);
    chk("pre_rst_pvld", {63'd0, out_pvld}, 64'd1);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("async_rst_pvld", {63'd0, out_pvld}, 64'd0);
    chk("async_rst_data", {15'd0, out_data}, 64'd0);
    chk("async_rst_sat", {63'd0, out_sat}, 64'd0);
    chk("async_rst_cnt", {32'd0, sat_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_prdy", {63'd0, in_prdy}, 64'd1);
    out_prdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_pvld", {63'd0, out_pvld}, 64'd0);
    end
    @(posedge clk); #1;
    send(32'hFFFF_FFFE, 6'd10);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
